// File: rtl/fetch_cycle.sv
// IF stage plus IF/ID register: one outstanding imem request, a 1-entry hold buffer,
// and stall/flush/redirect handling.
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // state  | meaning
  // S_REQ  | request PCF (unless StallF)
  // S_WAIT | request granted, waiting for imem_rvalid
  // S_HOLD | delivered instruction parked in buffer while StallD
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pcf, pcf_nx;
  logic        stale, stale_nx;
  logic [31:0] buf_q, buf_nx;
  logic [31:0] instr_nx, pcd_nx, pcp4_nx;
  logic        valid_nx;

  logic        grant;
  logic        deliver;
  logic [31:0] fetched;
  logic [31:0] pcf_plus4;

  assign grant     = imem_req & imem_gnt;
  assign deliver   = ((state == S_WAIT) & imem_rvalid & ~stale) | (state == S_HOLD);
  assign fetched   = (state == S_HOLD) ? buf_q : imem_rdata;
  assign pcf_plus4 = pcf + 32'd4;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_REQ;
      pcf      <= RESET_PC;
      stale    <= 1'b0;
      buf_q    <= NOP_INSTR;
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else begin
      state    <= state_nx;
      pcf      <= pcf_nx;
      stale    <= stale_nx;
      buf_q    <= buf_nx;
      InstrD   <= instr_nx;
      PCD      <= pcd_nx;
      PCPlus4D <= pcp4_nx;
      ValidD   <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pcf_nx   = pcf;
    stale_nx = stale;
    buf_nx   = buf_q;
    instr_nx = InstrD;
    pcd_nx   = PCD;
    pcp4_nx  = PCPlus4D;
    valid_nx = ValidD;

    if (PCSrcE) begin
      pcf_nx   = PCTargetE;
      instr_nx = NOP_INSTR;
      valid_nx = 1'b0;
      case (state)
        S_REQ: begin
          if (grant) begin
            stale_nx = 1'b1;
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            stale_nx = 1'b0;
            state_nx = S_REQ;
          end else begin
            stale_nx = 1'b1;
          end
        end
        default: state_nx = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ:   if (grant) state_nx = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid && stale) begin
            stale_nx = 1'b0;
            state_nx = S_REQ;
          end
        end
        S_HOLD:  state_nx = S_HOLD;
        default: state_nx = S_REQ;
      endcase

      // A flushed delivery is consumed: PCF still moves past it.
      if (deliver) begin
        if (FlushD || !StallD) begin
          pcf_nx   = pcf_plus4;
          state_nx = S_REQ;
        end else begin
          buf_nx   = fetched;
          state_nx = S_HOLD;
        end
      end

      if (FlushD) begin
        instr_nx = NOP_INSTR;
        valid_nx = 1'b0;
      end else if (!StallD) begin
        if (deliver) begin
          instr_nx = fetched;
          pcd_nx   = pcf;
          pcp4_nx  = pcf_plus4;
          valid_nx = 1'b1;
        end else begin
          instr_nx = NOP_INSTR;
          valid_nx = 1'b0;
        end
      end
    end
  end

  always_comb begin
    imem_req  = reset & (state == S_REQ) & ~StallF;
    imem_addr = {pcf[31:2], 2'b00};
  end

endmodule

// File: tb/tb_fetch_cycle.sv
// Scoreboard bench for fetch_cycle: a memory model pushes the expected fetch stream on
// each grant; a monitor pops and compares whenever IF/ID loads a valid instruction.
module tb_fetch_cycle;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clock = ~clock;

  fetch_cycle #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          presented = 0;
  logic [31:0] req_pc = RESET_PC;
  logic        rst_drv = 1'b0;
  logic        load_edge = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          lat = 0;
  int          mem_lat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock of stimulus, driven on the falling edge; returns before the next rising edge.
  task automatic cyc(input logic sf, input logic sd, input logic fd, input logic ps,
                     input logic [31:0] tgt, input logic g);
    @(negedge clock);
    reset       = rst_drv;
    StallF      = sf;
    StallD      = sd;
    FlushD      = fd;
    PCSrcE      = ps;
    PCTargetE   = tgt;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        lat--;
      end
    end
    imem_gnt = g;
    #1;
    if (imem_req && imem_gnt) begin
      check("req_addr", imem_addr, req_pc);
      sb_q.push_back('{pc: req_pc, instr: mem_word(req_pc)});
      pend      = 1'b1;
      pend_addr = imem_addr;
      lat       = mem_lat;
      req_pc    = req_pc + 32'd4;
    end
    if (ps) begin
      sb_q.delete();
      req_pc = {tgt[31:2], 2'b00};
    end
    if (!rst_drv) begin
      sb_q.delete();
      req_pc = RESET_PC;
    end
    load_edge = rst_drv && !sd && !fd && !ps;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #2;
    if (load_edge) begin
      if (ValidD) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual_pcd=%h required=no_instruction", PCD);
        end else begin
          e = sb_q.pop_front();
          presented++;
          check("sb_pcd", PCD, e.pc);
          check("sb_instr", InstrD, e.instr);
          check("sb_pcplus4", PCPlus4D, e.pc + 32'd4);
        end
      end else begin
        check("sb_bubble", InstrD, NOP);
      end
    end
  end

  initial begin
    logic ps;
    reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'd0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

    // reset
    rst_drv = 1'b0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_instr", InstrD, NOP);
    check("rst_pcd", PCD, 32'd0);
    check("rst_pcp4", PCPlus4D, 32'd0);
    check("rst_valid", {31'd0, ValidD}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    rst_drv = 1'b1;

    // 1-cycle memory after reset release
    mem_lat = 0;
    cyc(0, 0, 0, 0, 0, 1);
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t1_pcd0", PCD, 32'h0);
    check("t1_valid0", {31'd0, ValidD}, 32'd1);
    check("t1_addr4", imem_addr, 32'h4);
    cyc(0, 0, 0, 0, 0, 0);
    check("t1_bubble_v", {31'd0, ValidD}, 32'd0);
    check("t1_bubble_i", InstrD, NOP);
    cyc(0, 0, 0, 0, 0, 1);
    check("t1_pcd4", PCD, 32'h4);
    check("t1_valid4", {31'd0, ValidD}, 32'd1);
    check("t1_addr8", imem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 0);

    // grant delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("t2_req_stable", {31'd0, imem_req}, 32'd1);
      check("t2_addr_stable", imem_addr, 32'hC);
      if (i > 0) begin
        check("t2_wait_valid", {31'd0, ValidD}, 32'd0);
        check("t2_wait_instr", InstrD, NOP);
      end
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // StallD at delivery: IF/ID holds 0xC, 0x10 buffered
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    check("t3_hold_pcd", PCD, 32'hC);
    cyc(0, 1, 0, 0, 0, 0);
    check("t3_hold_pcd2", PCD, 32'hC);
    check("t3_hold_instr", InstrD, mem_word(32'hC));
    check("t3_no_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t3_hold_valid", {31'd0, ValidD}, 32'd1);
    check("t3_hold_pcd3", PCD, 32'hC);
    cyc(0, 0, 0, 0, 0, 1);
    check("t3_buf_pcd", PCD, 32'h10);
    check("t3_buf_instr", InstrD, mem_word(32'h10));
    check("t3_pcf_once", imem_addr, 32'h14);
    cyc(0, 0, 0, 0, 0, 0);

    // redirect while waiting
    mem_lat = 2;
    cyc(0, 0, 0, 0, 0, 1);
    mem_lat = 0;
    cyc(0, 0, 0, 1, 32'h100, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t4_addr", imem_addr, 32'h100);
    check("t4_drop_valid", {31'd0, ValidD}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t4_pcd", PCD, 32'h100);
    check("t4_valid", {31'd0, ValidD}, 32'd1);

    // redirect together with grant
    cyc(0, 0, 0, 1, 32'h200, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t5_addr", imem_addr, 32'h200);
    check("t5_drop_valid", {31'd0, ValidD}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t5_pcd", PCD, 32'h200);
    check("t5_instr", InstrD, mem_word(32'h200));

    // wrap-around and unaligned target
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t6_pcd", PCD, 32'hFFFF_FFFC);
    check("t6_pcp4", PCPlus4D, 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 1, 32'h303, 0);
    cyc(0, 0, 0, 1, 32'h400, 0);
    check("t6_unaligned", imem_addr, 32'h300);

    // FlushD alone at delivery
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    void'(sb_q.pop_front());
    cyc(0, 0, 0, 0, 0, 1);
    check("t7_flush_valid", {31'd0, ValidD}, 32'd0);
    check("t7_flush_instr", InstrD, NOP);
    check("t7_pcf_adv", imem_addr, 32'h404);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t7_pcd", PCD, 32'h404);

    // reset during S_WAIT, stray response afterwards
    mem_lat = 1;
    cyc(0, 0, 0, 0, 0, 1);
    mem_lat = 0;
    rst_drv = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    rst_drv = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t8_valid", {31'd0, ValidD}, 32'd0);
    check("t8_instr", InstrD, NOP);
    check("t8_req", {31'd0, imem_req}, 32'd1);
    check("t8_addr", imem_addr, RESET_PC);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("t8_pcd", PCD, RESET_PC);
    check("t8_instr0", InstrD, mem_word(RESET_PC));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(0, 3);
      ps = ($urandom_range(0, 15) == 0);
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          ps && ($urandom_range(0, 1) == 1), ps, $urandom & 32'hFFFF_FFFC,
          ($urandom_range(0, 1) == 1));
    end
    mem_lat = 0;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 1);
    check("drain_q", {31'd0, (sb_q.size() <= 1)}, 32'd1);
    check("progress", {31'd0, (presented >= 100)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
